// File: rtl/mux_out_arbiter_if.sv
// Class-FIFO side and downstream side of the transmit merge point.
// Show-ahead heads p0..p3 qualified by empty; registered output word.
interface mux_out_arbiter_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] p2;
    logic [WIDTH-1:0] p3;
    logic [3:0]       empty;
    logic [3:0]       pop;
    logic             pause;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;

    modport master (
        input  p0, p1, p2, p3, empty, pause,
        output pop, data_out, valid_out
    );

    modport slave (
        output p0, p1, p2, p3, empty, pause,
        input  pop, data_out, valid_out
    );
endinterface

// File: rtl/mux_out_arbiter.sv
// Round-robin merge of four class FIFOs into one registered stream.
// Optional class-bit checker: define MUX_OUT_CLASS_CHECK_EN.
module mux_out_arbiter #(
    parameter int WIDTH = 12
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        states,
    mux_out_arbiter_if.master bus,
    output logic              class_err,
    output logic [7:0]        word_cnt
);
    localparam logic [3:0] ST_FLUSH = 4'b0001;

    logic [1:0]       rr_ptr;
    logic [1:0]       gnt;
    logic [1:0]       idx;
    logic             found;
    logic             req;
    logic             flush;
    logic [WIDTH-1:0] head [4];
    logic [WIDTH-1:0] gnt_word;

    assign head[0] = bus.p0;
    assign head[1] = bus.p1;
    assign head[2] = bus.p2;
    assign head[3] = bus.p3;

    assign flush = (states == ST_FLUSH);
    assign req   = reset_L && !flush && !bus.pause
                 && (bus.empty != 4'b1111);

    // First non-empty class at or after rr_ptr, wrapping mod 4.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && !bus.empty[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    assign gnt_word = head[gnt];
    assign bus.pop  = req ? (4'b0001 << gnt) : 4'b0000;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            rr_ptr        <= '0;
            word_cnt      <= '0;
        end else if (flush) begin
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            rr_ptr        <= '0;
            word_cnt      <= '0;
        end else if (req) begin
            bus.data_out  <= gnt_word;
            bus.valid_out <= 1'b1;
            rr_ptr        <= gnt + 2'd1;
            word_cnt      <= word_cnt + 8'd1;
        end else begin
            bus.valid_out <= 1'b0;
        end
    end

`ifdef MUX_OUT_CLASS_CHECK_EN
    logic mismatch;

    // Mismatched words are still forwarded; only the flag records them.
    assign mismatch = (gnt_word[WIDTH-1 -: 2] != gnt);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            class_err <= 1'b0;
        end else if (flush) begin
            class_err <= 1'b0;
        end else if (req && mismatch) begin
            class_err <= 1'b1;
        end
    end
`else
    assign class_err = 1'b0;
`endif
endmodule

// File: doc/mux_out_arbiter.md
# mux_out_arbiter

Transmit-side merge point of the transaction layer: takes the four per-class queues (class 0–3, selected by bits [11:10] of each 12-bit word) and serialises them into one 12-bit output stream. Arbitration is round-robin among non-empty classes, with downstream back-pressure. It is the counterpart of the class demultiplexer on the receive side and obeys the same `states` control encoding.

## Interface
- `WIDTH`, 12: word width. Bits [WIDTH-1:WIDTH-2] carry the class.
- `clk` in, 1: single clock, rising edge.
- `reset_L` in, 1: asynchronous, active-low reset.
- `states` in, 4: one-hot control from the link FSM. 4'b0001 = RESET/flush; any other value = operational.
- `p0`,`p1`,`p2`,`p3` in, WIDTH each: head word of class FIFO 0..3. Show-ahead: valid whenever the matching `empty` bit is 0.
- `empty` in, 4: bit i = class FIFO i is empty.
- `pause` in, 1: downstream almost-full. No grant while high.
- `pop` out, 4: one-hot combinational read strobe to the class FIFOs.
- `data_out` out, WIDTH: registered output word.
- `valid_out` out, 1: registered; `data_out` is valid this cycle.
- `class_err` out, 1: sticky class-mismatch flag (see Configuration).
- `word_cnt` out, 8: count of words sent, wraps modulo 256.

## Operation
- Round-robin pointer `rr_ptr`, 2 bits. Search order is rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
- Request condition `req` = reset_L high, states != 4'b0001, pause low, and `empty` != 4'b1111.
- When `req` is true:
  - grant g = first i in search order with empty[i]=0.
  - pop[g]=1; all other pop bits are 0.
- When `req` is false: pop = 4'b0000.
- At the clock edge with a grant:
  - data_out <= p_g unmodified.
  - valid_out <= 1.
  - rr_ptr <= g+1 (mod 4).
  - word_cnt <= word_cnt+1; 255 wraps to 0.
- At a clock edge with no grant: valid_out <= 0; data_out holds its value; rr_ptr holds.
- Flush (states == 4'b0001, synchronous):
  - data_out <= 0, valid_out <= 0, rr_ptr <= 0, word_cnt <= 0, class_err <= 0.
  - pop forced to 0.
- Asynchronous reset (reset_L low): same values as flush, applied immediately. pop = 0 while reset_L is low.
- A reset or flush asserted mid-stream drops no FIFO data, because no pop is issued during it. The word already in `data_out` is discarded.

## Timing
- Latency: grant in cycle N (pop[g] high in cycle N), word on `data_out` with `valid_out`=1 in cycle N+1.
- Throughput: one word per cycle while `req` holds. Four continuously non-empty classes are served 0,1,2,3,0,…
- `pause` acts in the same cycle: pause high in cycle N means no pop in N and valid_out=0 in N+1. The word granted in N-1 still appears in N.
- `empty` and `pause` are sampled combinationally. The class FIFOs must update `empty` and the head word by the cycle after a pop.
- If only one class is non-empty, it is granted every cycle regardless of rr_ptr.

## Configuration
- `MUX_OUT_CLASS_CHECK_EN` defined:
  - On each grant, compare p_g[WIDTH-1:WIDTH-2] with g.
  - A mismatch sets `class_err` at the same edge. It stays set until flush or reset.
  - The mismatched word is still forwarded.
- Not defined: `class_err` is tied to 0 and no comparator logic is generated.

## Test plan
- Reset/flush:
  - Stimulus: reset_L=0 with all FIFOs non-empty; then reset_L=1 with states=4'b0001.
  - Required: pop=0, data_out=0, valid_out=0, word_cnt=0 throughout.
- Single class:
  - Stimulus: only class 2 non-empty, head 12'h8A5, states=4'b1000.
  - Required: pop=4'b0100; next cycle data_out=12'h8A5, valid_out=1; rr_ptr=3.
- Round-robin:
  - Stimulus: all four classes non-empty for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; word_cnt=8.
- Back-pressure:
  - Stimulus: pause=1 for 3 cycles mid-stream.
  - Required: pop=0 for those 3 cycles, valid_out=0 one cycle later; resumes at the saved rr_ptr.
- Wrap and flush mid-stream:
  - Stimulus: 257 words sent, then states=4'b0001 for one cycle.
  - Required: word_cnt=1 before the flush, 0 after; rr_ptr=0.
- Class check (macro defined):
  - Stimulus: class 1 head 12'hC00 (class bits 2'b11).
  - Required: word forwarded unchanged; class_err=1 until the next flush. Without the macro, class_err stays 0.
